traffic_safety_monitor: RTL and testbench
=========================================

TRAFFIC_SAFETY_MONITOR -- requirements
Module: traffic_safety_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3: minimum consecutive yellow cycles a car light must show before red.
REQ-002 Parameter MAX_HOLD, default 255: cycles with unchanged inputs after which the controller is declared stuck.
REQ-003 Parameter FLASH_HALF, default 5: cycles per half-period of fault flashing.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic  input  3 each  light codes from the traffic controller; bit2 red, bit1 yellow, bit0 green.
REQ-007 clear_fault  input  1  single-cycle request to leave fault mode.
REQ-008 h_car_out, v_car_out, h_walker_out, v_walker_out  output  3 each  registered lamp drive, same encoding.
REQ-009 fault  output  1  high while in fault mode.
REQ-010 fault_code  output  2  latched cause: 00 none, 01 illegal/conflict, 10 short yellow, 11 stuck.

Function
REQ-011 Legal input: every code exactly one-hot.
REQ-012 Conflict: h_car and v_car both non-red; h_car non-red with v_walker green; v_car non-red with h_walker green.
REQ-013 Illegal = not legal or conflict; evaluated every cycle on current inputs.
REQ-014 FSM states: NORMAL, SUSPECT, FLASH_ON, FLASH_OFF.
REQ-015 NORMAL: outputs = inputs registered, 1-cycle latency; illegal -> SUSPECT.
REQ-016 SUSPECT: outputs hold last legal registered values; illegal again -> FLASH_ON with code 01; legal -> NORMAL (one-cycle glitch tolerated).
REQ-017 Per car light, yellow counter increments each cycle code is yellow, saturating at MIN_YELLOW; clears when not yellow.
REQ-018 Car light yellow->red with counter < MIN_YELLOW, or green->red directly, in NORMAL -> FLASH_ON, code 10, next cycle.
REQ-019 Hold counter clears on any change of any input bit, else increments; reaching MAX_HOLD in NORMAL -> FLASH_ON, code 11.
REQ-020 Simultaneous causes: priority 01 > 10 > 11; fault_code latches first cause only, unchanged until clear.
REQ-021 FLASH_ON: car outputs 100, walker outputs 100; FLASH_OFF: car outputs 000, walker outputs 100.
REQ-022 Flash counter toggles FLASH_ON/FLASH_OFF every FLASH_HALF cycles; first FLASH_ON lasts full FLASH_HALF.
REQ-023 fault high in FLASH_ON and FLASH_OFF, registered with state.
REQ-024 clear_fault in either flash state with legal, conflict-free inputs -> NORMAL next cycle; fault_code -> 00; yellow, hold, flash counters cleared.
REQ-025 clear_fault with illegal inputs, or in NORMAL/SUSPECT, ignored.
REQ-026 Counters sized by $clog2 of parameter+1; no wrap: saturate at limit.

Reset
REQ-027 rst_n low asynchronously forces: state NORMAL, all lamp outputs 100, fault 0, fault_code 00, all counters 0.
REQ-028 Reset mid-fault fully abandons fault; first post-reset cycle treats inputs as new (hold counter starts at 0).
REQ-029 Reset deassertion synchronous to clk via the codebase's standard reset synchronizer upstream; block assumes it.

Structure
REQ-030 Shared package holds light encodings (RED=100, YELLOW=010, GREEN=001, DARK=000), FSM state typedef, fault code constants.
REQ-031 One sub-module, yellow_timer, instantiated twice (h_car, v_car): yellow counter plus short-yellow detect.
REQ-032 Legality/conflict check is combinational in the top; all outputs registered.

Verification
REQ-033 Normal cycle G(001)->Y 3 cycles->R, walkers opposite -> outputs mirror inputs 1 cycle late, fault 0.
REQ-034 h_car=001, v_car=001 for 1 cycle then legal -> SUSPECT, no fault; same for 2 cycles -> fault 1, code 01, car outputs flash 100/000 every 5 cycles.
REQ-035 h_car yellow 2 cycles then red -> fault 1, code 10; concurrent conflict same cycle -> code 01.
REQ-036 Inputs frozen 255 cycles -> fault 1, code 11; clear_fault with legal inputs -> NORMAL, code 00, pass-through resumes.
REQ-037 clear_fault while inputs illegal -> stays flashing; rst_n low during FLASH_OFF -> outputs 100 immediately, fault 0.

Source files
------------

// File: rtl/traffic_safety_monitor_pkg.sv
// Shared lamp encodings, FSM state type and fault cause codes for the
// traffic safety monitor and its yellow timer.
package traffic_safety_monitor_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  localparam logic [1:0] FC_NONE         = 2'b00;
  localparam logic [1:0] FC_ILLEGAL      = 2'b01;
  localparam logic [1:0] FC_SHORT_YELLOW = 2'b10;
  localparam logic [1:0] FC_STUCK        = 2'b11;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'b00,
    ST_SUSPECT   = 2'b01,
    ST_FLASH_ON  = 2'b10,
    ST_FLASH_OFF = 2'b11
  } state_e;

  function automatic logic is_one_hot(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/traffic_safety_monitor_yellow_timer.sv
// Yellow run counter for one car light; flags a red that follows too short a
// yellow or that follows green directly.
module traffic_safety_monitor_yellow_timer
  import traffic_safety_monitor_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic [2:0] code_i,
  output logic       short_o
);

  localparam int YW = $clog2(MIN_YELLOW + 1);

  logic [YW-1:0] cnt_q, cnt_d;
  logic [2:0]    prev_q;

  // Saturating count of consecutive yellow cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {YW{1'b0}};
    end else if (code_i == LIGHT_YELLOW) begin
      cnt_d = (cnt_q == YW'(MIN_YELLOW)) ? cnt_q : cnt_q + YW'(1);
    end else begin
      cnt_d = {YW{1'b0}};
    end
  end

  // Counter and previous-code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {YW{1'b0}};
      prev_q <= LIGHT_DARK;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= code_i;
    end
  end

  assign short_o = (code_i == LIGHT_RED) &&
                   (((prev_q == LIGHT_YELLOW) && (cnt_q < YW'(MIN_YELLOW))) ||
                    (prev_q == LIGHT_GREEN));

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety monitor between a traffic controller and its lamps: passes legal
// codes through one cycle late and falls back to red flashing on faults.
module traffic_safety_monitor
  import traffic_safety_monitor_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_HOLD   = 255,
  parameter int FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] h_car_traffic,
  input  logic [2:0] v_car_traffic,
  input  logic [2:0] h_walker_traffic,
  input  logic [2:0] v_walker_traffic,
  input  logic       clear_fault,
  output logic [2:0] h_car_out,
  output logic [2:0] v_car_out,
  output logic [2:0] h_walker_out,
  output logic [2:0] v_walker_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  state_e        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [11:0]   prev_in_q;
  logic          prev_valid_q;
  logic [11:0]   lamps_q, lamps_d;
  logic          fault_q, fault_d;

  logic [11:0] in_s;
  logic        legal_s, conflict_s, illegal_s, changed_s, stuck_s, clear_s;
  logic        h_short_s, v_short_s, short_s;

  assign in_s = {h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic};

  assign legal_s = is_one_hot(h_car_traffic) && is_one_hot(v_car_traffic) &&
                   is_one_hot(h_walker_traffic) && is_one_hot(v_walker_traffic);
  assign conflict_s = ((h_car_traffic != LIGHT_RED) && (v_car_traffic != LIGHT_RED)) ||
                      ((h_car_traffic != LIGHT_RED) && (v_walker_traffic == LIGHT_GREEN)) ||
                      ((v_car_traffic != LIGHT_RED) && (h_walker_traffic == LIGHT_GREEN));
  assign illegal_s = !legal_s || conflict_s;

  // The first cycle after reset or a clear always counts as a change.
  assign changed_s = !prev_valid_q || (in_s != prev_in_q);
  assign stuck_s   = (hold_q == HW'(MAX_HOLD));
  assign short_s   = h_short_s || v_short_s;

  traffic_safety_monitor_yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_h_car_yellow (
    .clk(clk), .rst_n(rst_n), .clr_i(clear_s), .code_i(h_car_traffic), .short_o(h_short_s)
  );

  traffic_safety_monitor_yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_v_car_yellow (
    .clk(clk), .rst_n(rst_n), .clr_i(clear_s), .code_i(v_car_traffic), .short_o(v_short_s)
  );

  // Next state, latched fault cause and flash phase counter.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    flash_d = flash_q;
    clear_s = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (short_s || stuck_s) begin
          state_d = ST_FLASH_ON;
          flash_d = {FW{1'b0}};
          if (illegal_s)    code_d = FC_ILLEGAL;
          else if (short_s) code_d = FC_SHORT_YELLOW;
          else              code_d = FC_STUCK;
        end else if (illegal_s) begin
          state_d = ST_SUSPECT;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_SUSPECT: begin
        if (illegal_s) begin
          state_d = ST_FLASH_ON;
          flash_d = {FW{1'b0}};
          code_d  = FC_ILLEGAL;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_FLASH_ON, ST_FLASH_OFF: begin
        if (clear_fault && !illegal_s) begin
          state_d = ST_NORMAL;
          code_d  = FC_NONE;
          flash_d = {FW{1'b0}};
          clear_s = 1'b1;
        end else if (flash_q == FW'(FLASH_HALF - 1)) begin
          state_d = (state_q == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
          flash_d = {FW{1'b0}};
        end else begin
          flash_d = flash_q + FW'(1);
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Saturating count of cycles with unchanged inputs.
  always_comb begin
    if (clear_s || changed_s) hold_d = {HW{1'b0}};
    else if (stuck_s)         hold_d = hold_q;
    else                      hold_d = hold_q + HW'(1);
  end

  // Lamp drive follows the state being entered so outputs are registered with it.
  always_comb begin
    lamps_d = lamps_q;
    fault_d = 1'b0;
    case (state_d)
      ST_NORMAL:    lamps_d = in_s;
      ST_SUSPECT:   lamps_d = lamps_q;
      ST_FLASH_ON: begin
        lamps_d = {LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED};
        fault_d = 1'b1;
      end
      ST_FLASH_OFF: begin
        lamps_d = {LIGHT_DARK, LIGHT_DARK, LIGHT_RED, LIGHT_RED};
        fault_d = 1'b1;
      end
      default:      lamps_d = lamps_q;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_NORMAL;
      code_q       <= FC_NONE;
      flash_q      <= {FW{1'b0}};
      hold_q       <= {HW{1'b0}};
      prev_in_q    <= 12'h000;
      prev_valid_q <= 1'b0;
      lamps_q      <= {LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED};
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      flash_q      <= flash_d;
      hold_q       <= hold_d;
      prev_in_q    <= in_s;
      prev_valid_q <= 1'b1;
      lamps_q      <= lamps_d;
      fault_q      <= fault_d;
    end
  end

  assign {h_car_out, v_car_out, h_walker_out, v_walker_out} = lamps_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Self-checking bench: directed scenarios plus randomized light patterns,
// compared every cycle against a behavioural model of the monitor's rules.
module tb_traffic_safety_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int MAX_HOLD   = 255;
  localparam int FLASH_HALF = 5;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  // {h_car, v_car, h_walker, v_walker}
  localparam logic [11:0] PA     = {G, R, G, R};
  localparam logic [11:0] PAY    = {Y, R, R, R};
  localparam logic [11:0] PR     = {R, R, R, R};
  localparam logic [11:0] PB     = {R, G, R, G};
  localparam logic [11:0] PBY    = {R, Y, R, R};
  localparam logic [11:0] PCONF  = {G, G, R, R};
  localparam logic [11:0] PCONF2 = {R, G, G, R};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] h_car_traffic = R, v_car_traffic = R, h_walker_traffic = R, v_walker_traffic = R;
  logic clear_fault = 1'b0;
  logic [2:0] h_car_out, v_car_out, h_walker_out, v_walker_out;
  logic fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_safety_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_HOLD(MAX_HOLD), .FLASH_HALF(FLASH_HALF)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_car_traffic(h_car_traffic), .v_car_traffic(v_car_traffic),
    .h_walker_traffic(h_walker_traffic), .v_walker_traffic(v_walker_traffic),
    .clear_fault(clear_fault),
    .h_car_out(h_car_out), .v_car_out(v_car_out),
    .h_walker_out(h_walker_out), .v_walker_out(v_walker_out),
    .fault(fault), .fault_code(fault_code)
  );

  // mode: 0 pass-through, 1 one bad cycle seen, 2 faulted; t = cycles since fault entry
  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] t;
    logic [1:0]  code;
    logic [11:0] out;
    logic [11:0] last;
    logic        have_last;
    logic [31:0] same;
    logic [31:0] yrun_h;
    logic [31:0] yrun_v;
    logic [2:0]  ylast_h;
    logic [2:0]  ylast_v;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n = '0;
    n.out = PR;
    return n;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input logic [11:0] v, input logic clr);
    mdl_t n;
    logic [2:0] hc, vc, hw, vw;
    logic legal, conflict, ill, sy, stuck, cleared;
    hc = v[11:9]; vc = v[8:6]; hw = v[5:3]; vw = v[2:0];
    legal = ($countones(hc) == 1) && ($countones(vc) == 1) &&
            ($countones(hw) == 1) && ($countones(vw) == 1);
    conflict = (hc != R && vc != R) || (hc != R && vw == G) || (vc != R && hw == G);
    ill = !legal || conflict;
    sy = ((hc == R) && ((c.ylast_h == Y && c.yrun_h < MIN_YELLOW) || c.ylast_h == G)) ||
         ((vc == R) && ((c.ylast_v == Y && c.yrun_v < MIN_YELLOW) || c.ylast_v == G));
    stuck = (c.same >= MAX_HOLD);
    cleared = (c.mode == 2'd2) && clr && !ill;
    n = c;
    n.t = c.t + 32'd1;
    if (c.mode == 2'd0) begin
      if (sy || stuck) begin
        n.mode = 2'd2;
        n.t = 32'd0;
        n.code = ill ? 2'd1 : (sy ? 2'd2 : 2'd3);
      end else if (ill) begin
        n.mode = 2'd1;
      end else begin
        n.out = v;
      end
    end else if (c.mode == 2'd1) begin
      if (ill) begin
        n.mode = 2'd2;
        n.t = 32'd0;
        n.code = 2'd1;
      end else begin
        n.mode = 2'd0;
        n.out = v;
      end
    end else if (cleared) begin
      n.mode = 2'd0;
      n.code = 2'd0;
      n.out = v;
    end
    if (cleared) begin
      n.yrun_h = 32'd0;
      n.yrun_v = 32'd0;
      n.same = 32'd0;
    end else begin
      n.yrun_h = (hc == Y) ? c.yrun_h + 32'd1 : 32'd0;
      n.yrun_v = (vc == Y) ? c.yrun_v + 32'd1 : 32'd0;
      n.same = (c.have_last && v == c.last) ? c.same + 32'd1 : 32'd0;
    end
    n.ylast_h = hc;
    n.ylast_v = vc;
    n.last = v;
    n.have_last = 1'b1;
    return n;
  endfunction

  function automatic logic [11:0] exp_lamps(input mdl_t c);
    if (c.mode != 2'd2) return c.out;
    if (((c.t / FLASH_HALF) % 2) == 0) return PR;
    return {3'b000, 3'b000, R, R};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else m <= mdl_next(m, {h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic}, clear_fault);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lamps", 32'({h_car_out, v_car_out, h_walker_out, v_walker_out}), 32'(exp_lamps(m)));
      chk("fault", 32'(fault), 32'(m.mode == 2'd2));
      chk("fault_code", 32'(fault_code), 32'(m.code));
    end
  end

  task automatic drive(input logic [11:0] v, input logic clr);
    {h_car_traffic, v_car_traffic, h_walker_traffic, v_walker_traffic} = v;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] lamps();
    return {h_car_out, v_car_out, h_walker_out, v_walker_out};
  endfunction

  logic [11:0] cur;
  logic [11:0] tbl [5];

  initial begin
    tbl[0] = PA; tbl[1] = PAY; tbl[2] = PR; tbl[3] = PB; tbl[4] = PBY;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_lamps", 32'(lamps()), 32'h924);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_code", 32'(fault_code), 32'h0);
    rst_n = 1'b1;

    drive(PA, 1'b0);
    chk("pass_latency", 32'(lamps()), 32'(PA));
    repeat (3) drive(PA, 1'b0);
    repeat (3) drive(PAY, 1'b0);
    chk("pass_yellow", 32'(h_car_out), 32'(Y));
    drive(PR, 1'b0);
    chk("full_yellow_ok", 32'(fault), 32'h0);

    drive(PB, 1'b0);
    drive(PCONF, 1'b0);
    chk("suspect_hold", 32'(lamps()), 32'(PB));
    chk("suspect_nofault", 32'(fault), 32'h0);
    drive(PB, 1'b0);
    chk("glitch_recover", 32'(lamps()), 32'(PB));

    repeat (3) drive(PBY, 1'b0);
    drive(PR, 1'b0);
    drive(PCONF, 1'b0);
    drive(PCONF, 1'b0);
    chk("conflict_fault", 32'(fault), 32'h1);
    chk("conflict_code", 32'(fault_code), 32'h1);
    chk("flash_on", 32'(lamps()), 32'h924);
    repeat (5) drive(PR, 1'b0);
    chk("flash_off", 32'(lamps()), 32'h024);

    drive(PCONF, 1'b1);
    chk("clear_illegal_ignored", 32'(fault), 32'h1);
    drive(PR, 1'b1);
    chk("clear_fault", 32'(fault), 32'h0);
    chk("clear_code", 32'(fault_code), 32'h0);
    drive(PA, 1'b0);
    chk("clear_pass", 32'(lamps()), 32'(PA));

    repeat (2) drive(PAY, 1'b0);
    drive(PR, 1'b0);
    chk("short_yellow_code", 32'(fault_code), 32'h2);
    drive(PR, 1'b1);
    drive(PA, 1'b0);
    repeat (2) drive(PAY, 1'b0);
    drive(PCONF2, 1'b0);
    chk("short_and_conflict_code", 32'(fault_code), 32'h1);
    chk("short_and_conflict_fault", 32'(fault), 32'h1);

    drive(PR, 1'b1);
    repeat (260) drive(PA, 1'b0);
    chk("stuck_fault", 32'(fault), 32'h1);
    chk("stuck_code", 32'(fault_code), 32'h3);
    chk("mdl_stuck_code", 32'(m.code), 32'h3);
    drive(PA, 1'b1);
    chk("stuck_clear_code", 32'(fault_code), 32'h0);
    drive(PAY, 1'b0);
    chk("stuck_clear_pass", 32'(lamps()), 32'(PAY));

    repeat (2) drive(PAY, 1'b0);
    drive(PR, 1'b0);
    repeat (2) drive(PCONF, 1'b0);
    repeat (6) drive(PR, 1'b0);
    chk("pre_reset_off", 32'(h_car_out), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_lamps", 32'(lamps()), 32'h924);
    chk("async_rst_fault", 32'(fault), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cur = PR;
    for (int i = 0; i < 400; i++) begin
      int r;
      int run;
      r = $urandom_range(0, 15);
      if (r < 11) cur = tbl[$urandom_range(0, 4)];
      else if (r < 13) cur = 12'($urandom);
      run = $urandom_range(1, 6);
      for (int k = 0; k < run; k++) begin
        if ($urandom_range(0, 199) == 0) begin
          rst_n = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end
        drive(cur, $urandom_range(0, 5) == 0);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
